// File: rtl/exec_mul_sequencer.sv
// Iterative radix-2 shift-add multiplier sequencer for the execute stage.
// Accepts MUL / SMULH / UMULH, stalls the front of the pipeline while it
// iterates one multiplier bit per cycle, and returns the selected 64-bit
// product slice with its destination register for write-back.
module exec_mul_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Rd_in,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       Rd_out,
    output logic             RegWrite_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] OP_SMULH = 2'b01;
    localparam logic [1:0] OP_UMULH = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 sign_q, sign_d;
    logic [1:0]           op_q, op_d;
    logic [4:0]           rd_lat_q, rd_lat_d;
    logic [4:0]           rd_out_q, rd_out_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 done_q, done_d;

    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH-1:0]   fixed_s;

    // Magnitude as an unsigned value; -2^(WIDTH-1) maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            mag = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag = v;
        end
    endfunction

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        product_d = product_q;
        mcand_d   = mcand_q;
        sign_d    = sign_q;
        op_d      = op_q;
        rd_lat_d  = rd_lat_q;
        rd_out_d  = rd_out_q;
        result_d  = result_q;
        done_d    = 1'b0;

        // 65-bit partial-sum add of the multiplicand into the high half.
        sum_s = {1'b0, product_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        // Two's complement of the full product for a negative signed result.
        if (sign_q) begin
            fixed_s = (~product_q) + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            fixed_s = product_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    sign_d    = (op == OP_SMULH) & (A[WIDTH-1] ^ B[WIDTH-1]);
                    mcand_d   = (op == OP_SMULH) ? mag(A) : A;
                    product_d = {{WIDTH{1'b0}}, ((op == OP_SMULH) ? mag(B) : B)};
                    count_d   = {CW{1'b0}};
                    op_d      = op;
                    rd_lat_d  = Rd_in;
                    state_d   = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (product_q[0]) begin
                        product_d = {sum_s, product_q[WIDTH-1:1]};
                    end else begin
                        product_d = {1'b0, product_q[2*WIDTH-1:1]};
                    end
                    count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                    if (count_q == CW'(WIDTH-1)) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    product_d = fixed_s;
                    if ((op_q == OP_SMULH) || (op_q == OP_UMULH)) begin
                        result_d = fixed_s[2*WIDTH-1:WIDTH];
                    end else begin
                        result_d = fixed_s[WIDTH-1:0];
                    end
                    rd_out_d = rd_lat_q;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                // Result is already committed; flush here cannot retract it.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= {CW{1'b0}};
            product_q <= {(2*WIDTH){1'b0}};
            mcand_q   <= {WIDTH{1'b0}};
            sign_q    <= 1'b0;
            op_q      <= 2'b00;
            rd_lat_q  <= 5'd0;
            rd_out_q  <= 5'd0;
            result_q  <= {WIDTH{1'b0}};
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            product_q <= product_d;
            mcand_q   <= mcand_d;
            sign_q    <= sign_d;
            op_q      <= op_d;
            rd_lat_q  <= rd_lat_d;
            rd_out_q  <= rd_out_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign stall        = ((state_q == S_IDLE) & start) | (state_q == S_CALC) | (state_q == S_FIX);
    assign done         = done_q;
    assign RegWrite_out = done_q;
    assign result       = result_q;
    assign Rd_out       = rd_out_q;

endmodule

// File: doc/exec_mul_sequencer.md
Name: exec_mul_sequencer

Overview:
- Multi-cycle 64x64 integer multiply unit next to the execute stage. It sequences an iterative radix-2 shift-add datapath and holds the pipeline while it runs.
- Decode issues MUL/SMULH/UMULH with latched operands. The block stalls the front of the pipeline, iterates one multiplier bit per cycle, and returns a 64-bit result with its destination register for write-back.

Parameters:
- WIDTH, 64, operand and result width. Iteration count equals WIDTH.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MUL (low 64 bits), 01 SMULH (signed high 64), 10 UMULH (unsigned high 64), 11 treated as MUL
- A  in  WIDTH  multiplicand (RdData1)
- B  in  WIDTH  multiplier (RdData2)
- Rd_in  in  5  destination register
- flush  in  1  synchronous abort (branch mispredict/flush)
- stall  out  1  hold upstream pipeline registers
- busy  out  1  state != IDLE
- done  out  1  one-cycle result-valid pulse
- result  out  WIDTH  product slice selected by op
- Rd_out  out  5  destination register for result
- RegWrite_out  out  1  equals done

Behaviour:
- States: IDLE, CALC, FIX, DONE. Encoding is free.
- Reset (reset=0, any time, including mid-operation): state=IDLE, count=0, product=0. Outputs: result=0, Rd_out=0, done=0, busy=0, RegWrite_out=0. stall=start (combinational, 0 while start=0).
- IDLE:
  - start=1 and flush=0 at an edge: latch Rd_in and op. Compute sign = (op==SMULH) & (A[63]^B[63]). Latch mcand = |A| and mplier = |B| for SMULH; raw A and B otherwise.
  - Set product = {64'b0, mplier}, count=0, go to CALC.
- CALC: each edge, if product[0]=1 then hi = hi + mcand as a 65-bit add. Then shift {carry, hi, lo} right by 1. count++. The edge where count==63 goes to FIX.
- FIX: if sign=1, product = two's complement of the 128-bit product. Then go to DONE.
- DONE: result = lo for MUL, hi for SMULH/UMULH. Register result at the FIX->DONE edge. done=1 and RegWrite_out=1 for exactly this one cycle. Next edge goes to IDLE.
- Latency: the accepting edge is e0, the result and done are visible after e65, and the block is back in IDLE after e66. A back-to-back start is accepted no earlier than e66.
- stall = (state==IDLE & start) | (state==CALC) | (state==FIX). stall is 0 in DONE so the pipeline captures the result that cycle.
- start while busy: ignored and not queued. The requester keeps it asserted only while stalled.
- flush in CALC or FIX: next edge goes to IDLE, done is never pulsed, and result/Rd_out keep their previous values.
- flush in DONE: done is still pulsed because the result is already committed.
- start and flush together in IDLE: flush wins and nothing is accepted.
- Magnitude of -2^63 is 2^63, representable unsigned. Do not use a signed abs.
- result and Rd_out hold their last value until the next DONE.

Test Plan:
- Reset released, start=1, op=MUL, A=3, B=5, Rd_in=7:
  - stall=1 from the start cycle.
  - done=1 exactly after e65 with result=15, Rd_out=7, RegWrite_out=1, stall=0.
  - busy=0 after e66.
- op=UMULH, A=B=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE. Repeat with op=MUL -> result=0x1.
- op=SMULH:
  - A=-1, B=1 -> result=0xFFFF_FFFF_FFFF_FFFF.
  - A=B=0x8000_0000_0000_0000 -> result=0x4000_0000_0000_0000.
  - A=-3, B=5 -> result=0xFFFF_FFFF_FFFF_FFFF.
- Second start with A=9 pulsed at cycle 10 of an ongoing op:
  - Ignored; the first result is unchanged and only one done pulse occurs.
  - A start held into e66 is accepted and its done comes 65 edges later.
- flush=1 at CALC count=30:
  - Next cycle busy=0 and stall=0, with no done.
  - result keeps its prior value (e.g. 15).
  - start and flush in the same IDLE cycle -> not accepted.
- reset driven to 0 asynchronously mid-CALC (between edges):
  - result=0, Rd_out=0, done=0 and busy=0 immediately.
  - After release, a fresh MUL 6*7 gives 42 on schedule.
